difftest_gpr_snapshot_seq: RTL and testbench
============================================

// Module: difftest_gpr_snapshot_seq
// PURPOSE
//  Sequencer feeding the arch int-reg difftest sink. On a commit event it captures a full
//  GPR snapshot, then streams it as fixed-size beats over a valid/ready channel so the
//  downstream DPI/bridge stage can use a narrow port. Sits between the regfile and the sink.
//  One snapshot in flight; commits arriving while busy are dropped and counted.
// PARAMETERS
//  NUM_REGS       32  architectural GPR count; must be a multiple of REGS_PER_BEAT
//  XLEN           64  register width in bits
//  REGS_PER_BEAT  4   registers per output beat; NUM_BEATS = NUM_REGS/REGS_PER_BEAT
//  DROP_CNT_W     16  width of the saturating drop counter
// PORTS
//  io_clock         in   1                     clock, all state on posedge
//  io_reset_n       in   1                     asynchronous, active-low reset
//  io_coreid        in   8                     hart id, sampled with the snapshot
//  io_commit_valid  in   1                     request a snapshot this cycle
//  io_gpr_flat      in   NUM_REGS*XLEN         GPR file; reg i at [i*XLEN +: XLEN]
//  io_out_valid     out  1                     beat available
//  io_out_ready     in   1                     sink accepts beat
//  io_out_data      out  REGS_PER_BEAT*XLEN    regs idx*RPB .. idx*RPB+RPB-1, lowest reg in LSBs
//  io_out_idx       out  $clog2(NUM_BEATS)     beat index, 0 first
//  io_out_last      out  1                     high on beat NUM_BEATS-1
//  io_out_coreid    out  8                     coreid captured with the snapshot
//  io_busy          out  1                     snapshot held / streaming
//  io_drop_cnt      out  DROP_CNT_W            commits dropped while busy, saturating
// BEHAVIOUR
//  Reset (async assert, sync-to-clock release): state IDLE; io_out_valid=0, io_out_idx=0,
//   io_out_last=0, io_busy=0, io_drop_cnt=0, io_out_coreid=0. Snapshot buffer not reset.
//  FSM: IDLE, STREAM.
//   IDLE & commit_valid: capture io_gpr_flat (reg 0 forced to 0) and io_coreid; idx<=0;
//    -> STREAM. io_out_valid high the following cycle (latency 1 from commit to beat 0).
//   STREAM: io_out_valid=1, io_busy=1. Handshake = valid&ready. On handshake with
//    idx<NUM_BEATS-1: idx<=idx+1. On handshake of last beat: -> IDLE, idx<=0.
//  Valid/ready: once io_out_valid rises, io_out_data/idx/last/coreid stay stable until
//   handshake; valid never deasserts without handshake. io_out_valid not gated by ready.
//  Simultaneous last-beat handshake & commit_valid: new snapshot captured, stay STREAM,
//   idx<=0, io_out_valid stays high (back-to-back, no bubble, no drop).
//  commit_valid in STREAM without last-beat handshake: ignored, io_drop_cnt+=1,
//   saturates at all-ones (no wrap).
//  io_out_last = (state==STREAM) && (idx==NUM_BEATS-1).
//  io_out_data is a combinational mux of the buffer by idx; no arithmetic beyond idx++.
//  Reset mid-stream: snapshot abandoned; no further beats; counter cleared.
//  io_gpr_flat only sampled in the capture cycle; later changes do not affect the stream.
// STRUCTURE
//  Package difftest_pkg: XLEN, NUM_GPR constants; seq_state_e {IDLE, STREAM} typedef.
//  Sub-module difftest_snap_buf: NUM_REGS x XLEN capture register with load enable and
//   beat-select read mux (RPB regs wide). Top holds FSM, idx counter, drop counter.
//  Assertions (non-synth): valid stable until ready; idx < NUM_BEATS; NUM_REGS%RPB==0.
// TESTING
//  1 Reset, gpr[i]=i*0x1111, commit 1 cycle, ready=1 -> valid next cycle, 8 beats idx 0..7,
//    beat0 data = {3,2,1,0}*0x1111 with reg0 = 0, last only on idx 7, then valid=0.
//  2 ready toggles 1/0 per cycle -> each beat held stable while ready=0, 16 cycles total,
//    data matches capture even though io_gpr_flat changes every cycle after commit.
//  3 commit_valid held high continuously, ready=1 -> beats stream back-to-back with no
//    valid bubble; drop_cnt increments 7 per snapshot (beats 0..6 cycles), not on last.
//  4 Force drop_cnt near max (ready=0, commit high 70000 cycles) -> saturates at 0xFFFF.
//  5 Assert io_reset_n=0 during beat 3 -> valid/busy/idx/drop_cnt 0 immediately (async);
//    after release, new commit restarts at idx 0 with new data.
//  6 coreid=0x5A at commit, changed to 0x00 after -> io_out_coreid=0x5A on all 8 beats.

Source files
------------

// File: rtl/difftest_pkg.sv
// Shared constants and FSM state type for the GPR difftest snapshot sequencer.
package difftest_pkg;

   localparam int XLEN    = 64;
   localparam int NUM_GPR = 32;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } seq_state_e;

endpackage

// File: rtl/difftest_snap_buf.sv
// GPR snapshot register: captures the whole register file on load and presents
// one beat (REGS_PER_BEAT registers, lowest register in the LSBs) selected by beat_sel.
module difftest_snap_buf
   import difftest_pkg::*;
#(
   parameter int NUM_REGS      = difftest_pkg::NUM_GPR,
   parameter int XLEN          = difftest_pkg::XLEN,
   parameter int REGS_PER_BEAT = 4,
   parameter int IDX_W         = 3
) (
   input  logic                            clk,
   input  logic                            load,
   input  logic [NUM_REGS*XLEN-1:0]        gpr_flat,
   input  logic [IDX_W-1:0]                beat_sel,
   output logic [REGS_PER_BEAT*XLEN-1:0]   beat_data
);

   localparam int NUM_BEATS = NUM_REGS / REGS_PER_BEAT;
   localparam int BEAT_W    = REGS_PER_BEAT * XLEN;
   // x0 is hardwired to zero, so its slot in beat 0 is cleared on capture
   localparam logic [BEAT_W-1:0] REG0_KEEP = ~BEAT_W'({XLEN{1'b1}});

   logic [BEAT_W-1:0] load_beat [NUM_BEATS];
   logic [BEAT_W-1:0] beat_mem  [NUM_BEATS];

   generate
      for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_beat
         localparam logic [BEAT_W-1:0] KEEP = (gi == 0) ? REG0_KEEP : {BEAT_W{1'b1}};
         assign load_beat[gi] = gpr_flat[gi*BEAT_W +: BEAT_W] & KEEP;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (load) begin
         beat_mem <= load_beat;
      end
   end

   assign beat_data = beat_mem[beat_sel];

endmodule

// File: rtl/difftest_gpr_snapshot_seq.sv
// Captures a GPR snapshot on commit and streams it as fixed-size beats over
// valid/ready; commits arriving while a snapshot is in flight are counted as drops.
module difftest_gpr_snapshot_seq
   import difftest_pkg::*;
#(
   parameter int NUM_REGS      = difftest_pkg::NUM_GPR,
   parameter int XLEN          = difftest_pkg::XLEN,
   parameter int REGS_PER_BEAT = 4,
   parameter int DROP_CNT_W    = 16,
   localparam int NUM_BEATS    = NUM_REGS / REGS_PER_BEAT,
   localparam int IDX_W        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
   input  logic                            io_clock,
   input  logic                            io_reset_n,
   input  logic [7:0]                      io_coreid,
   input  logic                            io_commit_valid,
   input  logic [NUM_REGS*XLEN-1:0]        io_gpr_flat,
   output logic                            io_out_valid,
   input  logic                            io_out_ready,
   output logic [REGS_PER_BEAT*XLEN-1:0]   io_out_data,
   output logic [IDX_W-1:0]                io_out_idx,
   output logic                            io_out_last,
   output logic [7:0]                      io_out_coreid,
   output logic                            io_busy,
   output logic [DROP_CNT_W-1:0]           io_drop_cnt
);

   seq_state_e              state_reg, state_next;
   logic [IDX_W-1:0]        idx_reg, idx_next;
   logic [DROP_CNT_W-1:0]   drop_cnt_reg;
   logic [7:0]              coreid_reg;
   logic                    load;
   logic                    drop_inc;
   logic                    at_last;

   assign at_last = (idx_reg == IDX_W'(NUM_BEATS - 1));

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      load       = 1'b0;
      drop_inc   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (io_commit_valid) begin
               load       = 1'b1;
               idx_next   = '0;
               state_next = STREAM;
            end
         end
         STREAM: begin
            if (io_out_ready && at_last) begin
               // final beat accepted: a coincident commit starts the next snapshot with no bubble
               idx_next = '0;
               if (io_commit_valid) begin
                  load = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               if (io_out_ready) begin
                  idx_next = idx_reg + IDX_W'(1);
               end
               drop_inc = io_commit_valid;
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

   always_ff @(posedge io_clock or negedge io_reset_n) begin
      if (!io_reset_n) begin
         state_reg    <= IDLE;
         idx_reg      <= '0;
         drop_cnt_reg <= '0;
         coreid_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         if (load) begin
            coreid_reg <= io_coreid;
         end
         if (drop_inc && (drop_cnt_reg != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
         end
      end
   end

   difftest_snap_buf #(
      .NUM_REGS      (NUM_REGS),
      .XLEN          (XLEN),
      .REGS_PER_BEAT (REGS_PER_BEAT),
      .IDX_W         (IDX_W)
   ) u_snap_buf (
      .clk       (io_clock),
      .load      (load),
      .gpr_flat  (io_gpr_flat),
      .beat_sel  (idx_reg),
      .beat_data (io_out_data)
   );

   assign io_out_valid  = (state_reg == STREAM);
   assign io_busy       = (state_reg == STREAM);
   assign io_out_idx    = idx_reg;
   assign io_out_last   = (state_reg == STREAM) && at_last;
   assign io_out_coreid = coreid_reg;
   assign io_drop_cnt   = drop_cnt_reg;

`ifndef SYNTHESIS
   a_valid_hold: assert property (@(posedge io_clock) disable iff (!io_reset_n)
      (io_out_valid && !io_out_ready) |=> (io_out_valid && $stable(io_out_data) &&
      $stable(io_out_idx) && $stable(io_out_last) && $stable(io_out_coreid)));
   a_idx_range: assert property (@(posedge io_clock) disable iff (!io_reset_n)
      (32'(io_out_idx) < NUM_BEATS));
   a_regs_div: assert property (@(posedge io_clock)
      ((NUM_REGS % REGS_PER_BEAT) == 0));
`endif

endmodule

// File: tb/tb_difftest_gpr_snapshot_seq.sv
// Randomized and directed bench for difftest_gpr_snapshot_seq against a snapshot/beat model.
module tb_difftest_gpr_snapshot_seq;

   localparam int NR  = 32;
   localparam int XL  = 64;
   localparam int RPB = 4;
   localparam int NB  = NR / RPB;
   localparam int BW  = RPB * XL;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [7:0]      coreid;
   logic            commit;
   logic [NR*XL-1:0] gpr_flat;
   logic            out_valid;
   logic            ready;
   logic [BW-1:0]   out_data;
   logic [2:0]      out_idx;
   logic            out_last;
   logic [7:0]      out_coreid;
   logic            busy;
   logic [15:0]     drop_cnt;

   logic [XL-1:0]   gpr [NR];

   always #5 clk = ~clk;

   always_comb begin
      gpr_flat = '0;
      for (int i = 0; i < NR; i++) gpr_flat[i*XL +: XL] = gpr[i];
   end

   difftest_gpr_snapshot_seq dut (
      .io_clock        (clk),
      .io_reset_n      (rst_n),
      .io_coreid       (coreid),
      .io_commit_valid (commit),
      .io_gpr_flat     (gpr_flat),
      .io_out_valid    (out_valid),
      .io_out_ready    (ready),
      .io_out_data     (out_data),
      .io_out_idx      (out_idx),
      .io_out_last     (out_last),
      .io_out_coreid   (out_coreid),
      .io_busy         (busy),
      .io_drop_cnt     (drop_cnt)
   );

   // reference model: the snapshot in flight, which beat is presented, drop tally
   bit            m_busy;
   int            m_beat;
   logic [XL-1:0] m_snap [NR];
   logic [7:0]    m_core;
   int            m_drops;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      logic [BW-1:0] exp_data;
      check_eq("valid", out_valid, m_busy);
      check_eq("busy", busy, m_busy);
      check_eq("idx", out_idx, m_beat);
      check_eq("last", out_last, m_busy && (m_beat == NB - 1));
      check_eq("coreid", out_coreid, m_core);
      check_eq("drop_cnt", drop_cnt, m_drops);
      if (m_busy) begin
         exp_data = '0;
         for (int j = 0; j < RPB; j++) exp_data[j*XL +: XL] = m_snap[m_beat*RPB + j];
         check_eq("data", out_data, exp_data);
      end
   endtask

   task automatic capture();
      for (int i = 0; i < NR; i++) m_snap[i] = (i == 0) ? '0 : gpr[i];
      m_core = coreid;
   endtask

   task automatic rand_gpr();
      for (int i = 0; i < NR; i++) gpr[i] = {$urandom, $urandom};
   endtask

   // drive one cycle of inputs, advance the model, then check after the edge
   task automatic step(input bit c, input bit r);
      commit = c;
      ready  = r;
      if (!m_busy) begin
         if (c) begin
            capture();
            m_beat = 0;
            m_busy = 1'b1;
         end
      end else begin
         if (r) $display("beat idx=%0d core=%02h lo=%016h last=%0b", out_idx, out_coreid, out_data[XL-1:0], out_last);
         if (r && m_beat == NB - 1) begin
            m_beat = 0;
            if (c) capture();
            else m_busy = 1'b0;
         end else begin
            if (r) m_beat++;
            if (c && m_drops < 65535) m_drops++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic hard_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_valid", out_valid, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_idx", out_idx, 3'd0);
      check_eq("rst_last", out_last, 1'b0);
      check_eq("rst_drop", drop_cnt, 16'd0);
      check_eq("rst_coreid", out_coreid, 8'd0);
      m_busy  = 1'b0;
      m_beat  = 0;
      m_drops = 0;
      m_core  = '0;
      commit  = 1'b0;
      ready   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [BW-1:0] exp_b0;
      rst_n  = 1'b1;
      commit = 1'b0;
      ready  = 1'b0;
      coreid = 8'h00;
      for (int i = 0; i < NR; i++) gpr[i] = '0;

      // 1: basic stream of a patterned register file
      hard_reset();
      for (int i = 0; i < NR; i++) gpr[i] = 64'(i) * 64'h1111;
      step(1'b1, 1'b1);
      exp_b0 = {64'h3333, 64'h2222, 64'h1111, 64'h0};
      check_eq("t1_beat0", out_data, exp_b0);
      for (int b = 0; b < NB; b++) begin
         check_eq("t1_last", out_last, b == NB - 1);
         step(1'b0, 1'b1);
      end
      check_eq("t1_idle", out_valid, 1'b0);

      // 2: ready toggling, register file changing every cycle after capture
      rand_gpr();
      step(1'b1, 1'b0);
      for (int k = 0; k < 2 * NB; k++) begin
         rand_gpr();
         step(1'b0, k[0]);
      end
      check_eq("t2_done", busy, 1'b0);

      // 3: commit held high, back-to-back snapshots
      hard_reset();
      for (int k = 0; k < 1 + 3 * NB; k++) begin
         rand_gpr();
         step(1'b1, 1'b1);
      end
      check_eq("t3_drops", drop_cnt, 16'd21);

      // 4: drop counter saturation
      hard_reset();
      for (int k = 0; k < 65600; k++) step(1'b1, 1'b0);
      check_eq("t4_sat", drop_cnt, 16'hFFFF);

      // 5: reset in the middle of beat 3, then a fresh snapshot
      hard_reset();
      rand_gpr();
      step(1'b1, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
      check_eq("t5_at3", out_idx, 3'd3);
      hard_reset();
      rand_gpr();
      step(1'b1, 1'b1);
      check_eq("t5_restart", out_idx, 3'd0);
      for (int b = 0; b < NB; b++) step(1'b0, 1'b1);

      // 6: coreid sampled only with the snapshot
      hard_reset();
      rand_gpr();
      coreid = 8'h5A;
      step(1'b1, 1'b1);
      coreid = 8'h00;
      for (int b = 0; b < NB; b++) begin
         check_eq("t6_coreid", out_coreid, 8'h5A);
         step(1'b0, 1'b1);
      end

      // randomized traffic
      hard_reset();
      for (int k = 0; k < 1500; k++) begin
         rand_gpr();
         coreid = 8'($urandom);
         step($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
